// File: rtl/pulse_stim_pkg.sv
// Shared types and constants for the pulse stimulus generator.
package pulse_stim_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned CNT_W  = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [CNT_W-1:0]  MISMATCH_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Right-shifting Galois step; a nonzero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : LFSR_W'(0));
  endfunction

endpackage

// File: rtl/pulse_stim_gen_if.sv
// Stimulus/observation bundle between the generator and the counter under test.
interface pulse_stim_gen_if #(
  parameter int unsigned P_BIT = 4
);
  import pulse_stim_pkg::*;

  logic             start;
  logic [CNT_W-1:0] num_txn;
  logic             busy;
  logic             done;
  logic             enable;
  logic             wenable;
  logic [P_BIT-1:0] wcount;
  logic [P_BIT-1:0] count;
  logic             carry;
  logic [P_BIT-1:0] exp_count;
  logic             exp_carry;
  logic [CNT_W-1:0] mismatch_cnt;

  modport master (
    input  start, num_txn, count, carry,
    output busy, done, enable, wenable, wcount, exp_count, exp_carry, mismatch_cnt
  );

  modport slave (
    output start, num_txn, count, carry,
    input  busy, done, enable, wenable, wcount, exp_count, exp_carry, mismatch_cnt
  );

endinterface

// File: rtl/pulse_ref_model.sv
// Behavioural counter model: load beats increment, carry only on an increment wrap.
module pulse_ref_model #(
  parameter int unsigned P_BIT = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             wenable,
  input  logic [P_BIT-1:0] wcount,
  output logic [P_BIT-1:0] exp_count,
  output logic             exp_carry
);

  logic [P_BIT:0] inc_c;

  assign inc_c = {1'b0, exp_count} + (P_BIT+1)'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_count <= '0;
      exp_carry <= 1'b0;
    end else if (wenable) begin
      exp_count <= wcount;
      exp_carry <= 1'b0;
    end else if (enable) begin
      exp_count <= inc_c[P_BIT-1:0];
      exp_carry <= inc_c[P_BIT];
    end else begin
      exp_carry <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_stim_gen.sv
// LFSR-driven stimulus generator for an up-counter with optional in-line checker.
// Define PULSE_STIM_GEN_MODEL_EN to build the reference model and compare logic.
module pulse_stim_gen
  import pulse_stim_pkg::*;
#(
  parameter int unsigned P_BIT      = 4,
  parameter logic [15:0] P_SEED     = 16'hACE1,
  parameter logic [7:0]  P_LOAD_THR = 8'd32
) (
  input logic              clk,
  input logic              resetn,
  pulse_stim_gen_if.master bus
);

  localparam logic [LFSR_W-1:0] SEED = (P_SEED == 16'h0000) ? DEFAULT_SEED : P_SEED;

  state_e             state_q, state_d;
  logic               start_acc_c;
  logic [CNT_W-1:0]   remain_q;
  logic [LFSR_W-1:0]  lfsr_q;
  logic               enable_q;
  logic               wenable_q;
  logic [P_BIT-1:0]   wcount_q;
  logic               busy_q;
  logic               done_q;

  // Next-state logic; start is only looked at while idle.
  always_comb begin
    state_d     = state_q;
    start_acc_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          start_acc_c = 1'b1;
          state_d     = (bus.num_txn != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (remain_q == CNT_W'(1)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and remaining RUN-cycle counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc_c) begin
        remain_q <= bus.num_txn;
      end else if (state_q == ST_RUN) begin
        remain_q <= remain_q - CNT_W'(1);
      end
    end
  end

  // Stimulus is registered on the edge entering each RUN cycle so it is valid
  // exactly during RUN; the LFSR steps once per RUN cycle and holds otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q    <= SEED;
      enable_q  <= 1'b0;
      wenable_q <= 1'b0;
      wcount_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= (state_d == ST_RUN) || (state_d == ST_FLUSH);
      done_q <= (state_d == ST_DONE);
      if (state_d == ST_RUN) begin
        lfsr_q    <= lfsr_step(lfsr_q);
        enable_q  <= lfsr_q[0] | lfsr_q[1];
        wenable_q <= (lfsr_q[15:8] < P_LOAD_THR);
        wcount_q  <= lfsr_q[P_BIT+1:2];
      end else begin
        enable_q  <= 1'b0;
        wenable_q <= 1'b0;
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.enable  = enable_q;
  assign bus.wenable = wenable_q;
  assign bus.wcount  = wcount_q;

`ifdef PULSE_STIM_GEN_MODEL_EN
  logic [P_BIT-1:0] exp_count_w;
  logic             exp_carry_w;
  logic             first_q;
  logic [CNT_W-1:0] mismatch_q;
  logic             cmp_c;
  logic             diff_c;

  pulse_ref_model #(
    .P_BIT (P_BIT)
  ) u_ref_model (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable_q),
    .wenable   (wenable_q),
    .wcount    (wcount_q),
    .exp_count (exp_count_w),
    .exp_carry (exp_carry_w)
  );

  // The first RUN cycle still shows the pre-run counter, so it is not compared.
  assign cmp_c  = ((state_q == ST_RUN) && !first_q) || (state_q == ST_FLUSH);
  assign diff_c = {bus.count, bus.carry} != {exp_count_w, exp_carry_w};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      first_q    <= 1'b0;
      mismatch_q <= '0;
    end else begin
      first_q <= (state_q == ST_IDLE);
      if (start_acc_c) begin
        mismatch_q <= '0;
      end else if (cmp_c && diff_c && (mismatch_q != MISMATCH_MAX)) begin
        mismatch_q <= mismatch_q + CNT_W'(1);
      end
    end
  end

  assign bus.exp_count    = exp_count_w;
  assign bus.exp_carry    = exp_carry_w;
  assign bus.mismatch_cnt = mismatch_q;
`else
  logic unused_obs_c;

  assign unused_obs_c     = ^{bus.count, bus.carry};
  assign bus.exp_count    = '0;
  assign bus.exp_carry    = 1'b0;
  assign bus.mismatch_cnt = '0;
`endif

endmodule
